// File: rtl/pow2_expand_8.sv
// Serial power-of-2 expander: out = mant << exp, saturating to all ones.
// Shifts one bit per cycle; request/result use valid/ready handshakes.
module pow2_expand_8 #(
    parameter int DATA_W = 8,
    parameter int EXP_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [DATA_W-1:0] mant_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_val,
    output logic              out_sat,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // The producer holds data stable while valid && !ready; the request side
    // samples exp_in/mant_in only on the accept edge.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [EXP_W-1:0]    cnt_q, cnt_d;
    logic                sat_q, sat_d;
    logic [DATA_W-1:0]   out_val_q, out_val_d;
    logic                out_sat_q, out_sat_d;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_d     = sat_q;
        out_val_d = out_val_q;
        out_sat_d = out_sat_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = mant_in;
                    cnt_d   = exp_in;
                    sat_d   = 1'b0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    // Any 1 leaving the MSB makes the result saturate.
                    sat_d = sat_q | acc_q[DATA_W-1];
                    acc_d = acc_q << 1;
                    cnt_d = cnt_q - EXP_W'(1);
                end else begin
                    out_val_d = sat_q ? {DATA_W{1'b1}} : acc_q;
                    out_sat_d = sat_q;
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_q     <= 1'b0;
            out_val_q <= '0;
            out_sat_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_q     <= sat_d;
            out_val_q <= out_val_d;
            out_sat_q <= out_sat_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == HOLD);
    assign out_val   = out_val_q;
    assign out_sat   = out_sat_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pow2_expand_8.sv
// Directed and randomized checks of pow2_expand_8 against an arithmetic
// model: result = min(mant << exp, 0xFF), sat = (mant << exp) > 0xFF.
module tb_pow2_expand_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] exp_in = '0;
    logic [7:0] mant_in = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_val;
    logic       out_sat;
    logic [1:0] dbg_state;

    int checks = 0;
    int failures = 0;

    pow2_expand_8 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .exp_in    (exp_in),
        .mant_in   (mant_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_val   (out_val),
        .out_sat   (out_sat),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int model_val(input int m, input int e);
        int full;
        full = m * (1 << e);
        return (full > 255) ? 255 : full;
    endfunction

    function automatic int model_sat(input int m, input int e);
        return ((m * (1 << e)) > 255) ? 1 : 0;
    endfunction

    // Present a request and let it be accepted on the next edge.
    task automatic send(input logic [7:0] m, input logic [2:0] e);
        check("in_ready_before_send", int'(in_ready), 1);
        in_valid = 1'b1;
        mant_in  = m;
        exp_in   = e;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for the result, optionally toggling in_valid with junk while busy.
    task automatic wait_result(input logic [7:0] m, input logic [2:0] e, input bit noise);
        int lat = 0;
        while (!out_valid && lat < 16) begin
            check("in_ready_busy", int'(in_ready), 0);
            if (noise) begin
                in_valid = 1'($urandom_range(0, 1));
                mant_in  = 8'($urandom);
                exp_in   = 3'($urandom);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        check("latency", lat, int'(e) + 1);
        check("out_val", int'(out_val), model_val(int'(m), int'(e)));
        check("out_sat", int'(out_sat), model_sat(int'(m), int'(e)));
    endtask

    // Hold the result for some stall cycles, then complete the handshake.
    task automatic release_result(input int stall, input logic [7:0] m, input logic [2:0] e);
        for (int i = 0; i < stall; i++) begin
            tick();
            check("hold_valid", int'(out_valid), 1);
            check("hold_val", int'(out_val), model_val(int'(m), int'(e)));
            check("hold_sat", int'(out_sat), model_sat(int'(m), int'(e)));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_after_hs", int'(out_valid), 0);
        check("ready_after_hs", int'(in_ready), 1);
        check("val_kept_after_hs", int'(out_val), model_val(int'(m), int'(e)));
    endtask

    task automatic full_req(input logic [7:0] m, input logic [2:0] e, input int stall);
        send(m, e);
        wait_result(m, e, 1'b0);
        release_result(stall, m, e);
    endtask

    initial begin
        logic [7:0] m;
        logic [2:0] e;
        int         lat;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", int'(in_ready), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_val", int'(out_val), 0);
        check("rst_out_sat", int'(out_sat), 0);
        check("rst_state", int'(dbg_state), 0);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", int'(in_ready), 1);
        tick();

        // Directed arithmetic and latency corners
        full_req(8'h01, 3'd7, 0);
        full_req(8'h03, 3'd7, 1);
        full_req(8'h40, 3'd1, 0);
        full_req(8'h40, 3'd2, 0);
        full_req(8'hA5, 3'd0, 0);
        full_req(8'h00, 3'd5, 0);
        full_req(8'h00, 3'd7, 0);
        full_req(8'hFF, 3'd0, 0);
        full_req(8'h80, 3'd1, 0);

        // Backpressure: second request waits until after the handshake
        send(8'h21, 3'd3);
        wait_result(8'h21, 3'd3, 1'b0);
        in_valid = 1'b1;
        mant_in  = 8'h05;
        exp_in   = 3'd2;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", int'(out_valid), 1);
            check("bp_in_ready", int'(in_ready), 0);
            check("bp_val", int'(out_val), model_val(8'h21, 3));
            check("bp_sat", int'(out_sat), model_sat(8'h21, 3));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_hs_valid", int'(out_valid), 0);
        check("bp_hs_in_ready", int'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", int'(in_ready), 0);
        wait_result(8'h05, 3'd2, 1'b0);
        release_result(0, 8'h05, 3'd2);

        // Reset in the middle of a shift
        send(8'h11, 3'd6);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_in_ready", int'(in_ready), 0);
        check("midrst_valid", int'(out_valid), 0);
        check("midrst_val", int'(out_val), 0);
        check("midrst_sat", int'(out_sat), 0);
        rst = 1'b0;
        #1;
        check("midrst_in_ready_after", int'(in_ready), 1);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) lat++;
        end
        check("midrst_no_valid_pulse", lat, 0);
        check("midrst_idle_state", int'(dbg_state), 0);
        full_req(8'h11, 3'd2, 0);

        // Reset while holding a result
        send(8'h09, 3'd1);
        wait_result(8'h09, 3'd1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("holdrst_valid", int'(out_valid), 0);
        check("holdrst_val", int'(out_val), 0);
        check("holdrst_in_ready", int'(in_ready), 1);
        tick();

        // Random requests with junk in_valid while busy and random stalls
        for (int n = 0; n < 1000; n++) begin
            m = 8'($urandom);
            if ($urandom_range(0, 7) == 0) m = 8'h00;
            e = 3'($urandom_range(0, 7));
            send(m, e);
            wait_result(m, e, 1'b1);
            release_result(int'($urandom_range(0, 3)), m, e);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog timeout");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
